// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dct_pkg
//  Description : Shared definitions for the sequenced 8x8 2-D DCT block.
//                DCT_PTS     - points per 1-D transform (engine is 8-point)
//                seq_state_t - row/column sequencer states
//                idx_t       - 3-bit row/column index into the 8x8 buffer
//  Revision    : 1.0 - initial release
// ============================================================================
package dct_pkg;

  localparam int DCT_PTS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROWS = 2'd1,
    COLS = 2'd2
  } seq_state_t;

  typedef logic [2:0] idx_t;

endpackage : dct_pkg
`default_nettype wire

// File: rtl/dct_transpose_buf.sv
`default_nettype none
// ============================================================================
//  Module      : dct_transpose_buf
//  Description : 8x8 array of N-bit elements. One full row is written per
//                clock; one full column is read combinationally. Writing
//                rows and reading columns performs the transpose between the
//                row and column DCT passes.
//  Ports       : clk     - rising-edge clock
//                wr_en   - write wr_data into row wr_row
//                wr_row  - destination row index
//                wr_data - row data, element 0 in the MSBs
//                rd_col  - column index to read
//                rd_data - column data, element from row 0 in the MSBs
//  Notes       : Storage is intentionally not reset; its contents are only
//                read after a full block of rows has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  idx_t                 wr_row,
  input  logic [DCT_PTS*N-1:0] wr_data,
  input  idx_t                 rd_col,
  output logic [DCT_PTS*N-1:0] rd_data
);

  logic [N-1:0] r_mem [DCT_PTS][DCT_PTS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < DCT_PTS; c++) begin
        r_mem[wr_row][c] <= wr_data[(DCT_PTS-1-c)*N +: N];
      end
    end
  end

  // Column read: element r of the output vector comes from row r.
  for (genvar r = 0; r < DCT_PTS; r++) begin : g_rd_row
    assign rd_data[(DCT_PTS-1-r)*N +: N] = r_mem[r][rd_col];
  end

endmodule : dct_transpose_buf
`default_nettype wire

// File: rtl/dct2d_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dct2d_seq
//  Description : Sequences one external combinational 8-point 1-D DCT engine
//                through 8 row passes and 8 column passes to produce an 8x8
//                2-D DCT, emitted one coefficient column per handshake.
//  Ports       : clk, reset            - clock, async active-high reset
//                in_valid/in_ready     - input row handshake
//                in_row                - input row, element 0 in the MSBs
//                flush                 - synchronous abort of current block
//                eng_in / eng_out      - engine data_in / data_out
//                out_valid/out_ready   - output column handshake
//                out_col               - registered coefficient column
//                out_last              - out_col is column 7
//                busy                  - sequencer not idle
//                blk_count             - completed blocks (optional)
//  Options     : `define DCT2D_SEQ_BLKCNT_EN adds the 16-bit blk_count
//                output counting out_last handshakes (reset-cleared only).
//  Revision    : 1.0 - initial release
// ============================================================================
module dct2d_seq
  import dct_pkg::*;
#(
  parameter int N   = 16,
  parameter int PTS = 8      // must equal DCT_PTS; the engine is 8-point
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PTS*N-1:0] in_row,
  input  logic             flush,
  output logic [PTS*N-1:0] eng_in,
  input  logic [PTS*N-1:0] eng_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTS*N-1:0] out_col,
  output logic             out_last,
  output logic             busy
`ifdef DCT2D_SEQ_BLKCNT_EN
  ,
  output logic [15:0]      blk_count
`endif
);

  // col_cnt needs one extra bit: after column 7 is loaded it sits at 8,
  // which blocks any further load while the last column waits for out_ready.
  localparam int COL_CW = 4;

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  idx_t              r_row_cnt;
  logic [COL_CW-1:0] r_col_cnt;

  logic              w_row_hs;
  logic              w_out_hs;
  logic              w_last_hs;
  logic              w_load;
  logic              w_buf_wr;
  logic [PTS*N-1:0]  w_col_data;

  // --------------------------------------------------------------------------
  // Transpose buffer: rows written from the engine during ROWS, columns fed
  // back to the engine during COLS.
  // --------------------------------------------------------------------------
  assign w_buf_wr = w_row_hs & ~flush;

  dct_transpose_buf #(
    .N (N)
  ) u_tbuf (
    .clk     (clk),
    .wr_en   (w_buf_wr),
    .wr_row  (r_row_cnt),
    .wr_data (eng_out),
    .rd_col  (r_col_cnt[2:0]),
    .rd_data (w_col_data)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state, handshake decode and engine input mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    busy        = (r_state != IDLE);
    eng_in      = in_row;
    w_row_hs    = 1'b0;
    w_load      = 1'b0;
    w_out_hs    = out_valid & out_ready;
    w_last_hs   = out_valid & out_ready & out_last;

    case (r_state)
      IDLE: begin
        w_row_hs = in_valid;
        if (in_valid) begin
          w_state_nxt = ROWS;
        end
      end
      ROWS: begin
        w_row_hs = in_valid;
        if (in_valid && (r_row_cnt == 3'd7)) begin
          w_state_nxt = COLS;
        end
      end
      COLS: begin
        in_ready = 1'b0;
        eng_in   = w_col_data;
        // Load into an empty register, or refill on a handshake while
        // columns remain; col_cnt==8 means the last column is held.
        w_load   = ~out_valid | (w_out_hs & (r_col_cnt <= 4'd7));
        if (w_last_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (flush) begin
      w_state_nxt = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Counters and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_cnt <= '0;
      r_col_cnt <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_col   <= '0;
    end else if (flush) begin
      r_row_cnt <= '0;
      r_col_cnt <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (w_row_hs) begin
        // 3-bit counter wraps 7 -> 0 on the last row of the block
        r_row_cnt <= r_row_cnt + 3'd1;
      end
      if (w_load) begin
        out_col   <= eng_out;
        out_last  <= (r_col_cnt == 4'd7);
        out_valid <= 1'b1;
        r_col_cnt <= r_col_cnt + 4'd1;
      end else if (w_last_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        r_col_cnt <= '0;
      end
    end
  end

`ifdef DCT2D_SEQ_BLKCNT_EN
  // Completed-block counter; survives flush, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_count <= '0;
    end else if (w_last_hs && !flush) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule : dct2d_seq
`default_nettype wire

// File: tb/tb_dct2d_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dct2d_seq
//  Description : Self-checking bench for dct2d_seq. Provides the 1-D engine
//                (identity or a fixed-point 8-point DCT) and a matrix-level
//                reference of the 2-D row/column transform.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dct2d_seq;

  localparam int N   = 16;
  localparam int PTS = 8;

  typedef logic [PTS*N-1:0] word_t;

  typedef struct {
    word_t row;
    word_t exp_col;
    logic  exp_last;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  in_valid;
  logic  in_ready;
  word_t in_row;
  logic  flush;
  word_t eng_in;
  word_t eng_out;
  logic  out_valid;
  logic  out_ready;
  word_t out_col;
  logic  out_last;
  logic  busy;
`ifdef DCT2D_SEQ_BLKCNT_EN
  logic [15:0] blk_count;
`endif

  bit    use_dct;
  int    checks = 0;
  int    errors = 0;
  int    first_cyc;
  word_t first_col;
  vec_t  tbl [PTS];

  always #5 clk = ~clk;

  dct2d_seq #(.N(N), .PTS(PTS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .flush     (flush),
    .eng_in    (eng_in),
    .eng_out   (eng_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy)
`ifdef DCT2D_SEQ_BLKCNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  // ---------------- engine model ----------------
  function automatic int coef(int k, int n);
    real ck;
    real v;
    ck = (k == 0) ? $sqrt(0.125) : 0.5;
    v  = 256.0 * ck * $cos(real'((2*n+1)*k) * 3.14159265358979 / 16.0);
    return int'(v);
  endfunction

  function automatic word_t dct_vec(word_t x);
    word_t  y;
    longint acc;
    y = '0;
    for (int k = 0; k < PTS; k++) begin
      acc = 0;
      for (int n = 0; n < PTS; n++) begin
        acc += longint'($signed(x[(PTS-1-n)*N +: N])) * longint'(coef(k, n));
      end
      y[(PTS-1-k)*N +: N] = 16'(acc >>> 8);
    end
    return y;
  endfunction

  always_comb eng_out = use_dct ? dct_vec(eng_in) : eng_in;

  // ---------------- reference: 2-D transform of tbl[].row ----------------
  task automatic build_expected();
    word_t mid [PTS];
    word_t colv;
    for (int r = 0; r < PTS; r++) begin
      mid[r] = use_dct ? dct_vec(tbl[r].row) : tbl[r].row;
    end
    for (int c = 0; c < PTS; c++) begin
      colv = '0;
      for (int r = 0; r < PTS; r++) begin
        colv[(PTS-1-r)*N +: N] = mid[r][(PTS-1-c)*N +: N];
      end
      tbl[c].exp_col  = use_dct ? dct_vec(colv) : colv;
      tbl[c].exp_last = (c == PTS-1);
    end
  endtask

  task automatic random_rows();
    for (int r = 0; r < PTS; r++) begin
      tbl[r].row = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int gap_pct);
    int guard;
    for (int r = 0; r < PTS; r++) begin
      guard = 0;
      while ($urandom_range(0, 99) < gap_pct && guard < 4) begin
        in_valid = 1'b0;
        in_row   = {$urandom, $urandom, $urandom, $urandom};
        step();
        guard++;
      end
      in_valid = 1'b1;
      in_row   = tbl[r].row;
      guard    = 0;
      while (!in_ready && guard < 50) begin
        step();
        guard++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready=1; mode 1: 1,0,0 pattern; mode 2: random
  task automatic collect_block(input int mode);
    int    got;
    int    cyc;
    bit    stalled;
    word_t held_col;
    logic  held_last;
    got = 0; cyc = 0; stalled = 0; first_cyc = -1;
    held_col = '0; held_last = 1'b0;
    while (got < PTS && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode != 0) begin
        in_valid = 1'($urandom_range(0, 1));
        in_row   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (out_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          first_col = out_col;
        end
        chk("in_ready_low_in_cols", in_ready, 0);
        if (stalled) begin
          chk("stall_col_hold", out_col, held_col);
          chk("stall_last_hold", out_last, held_last);
        end
        if (out_ready) begin
          chk($sformatf("col%0d_data", got), out_col, tbl[got].exp_col);
          chk($sformatf("col%0d_last", got), out_last, tbl[got].exp_last);
          got++;
          stalled = 0;
        end else begin
          stalled   = 1;
          held_col  = out_col;
          held_last = out_last;
        end
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    if (got < PTS) chk("collect_timeout", got, PTS);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("no_extra_column", out_valid, 0);
      step();
    end
    chk("idle_after_block_busy", busy, 0);
    chk("idle_after_block_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int seen;
    reset = 1'b0; in_valid = 1'b0; in_row = '0; flush = 1'b0;
    out_ready = 1'b0; use_dct = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_col", out_col, '0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    step(); step();
    #2 reset = 1'b0;
    step();

    // 1) identity engine, table of rows 16*r+c and transposed-back columns
    use_dct = 1'b0;
    for (int i = 0; i < PTS; i++) begin
      for (int c = 0; c < PTS; c++) begin
        tbl[i].row[(PTS-1-c)*N +: N]     = 16'(16*i + c);
        tbl[i].exp_col[(PTS-1-c)*N +: N] = 16'(16*c + i);
      end
      tbl[i].exp_last = (i == PTS-1);
    end
    send_block(0);
    chk("cols_entry_out_valid", out_valid, 0);
    chk("cols_entry_busy", busy, 1);
    chk("cols_entry_in_ready", in_ready, 0);
    collect_block(0);
    chk("first_column_latency", first_cyc, 1);

    // 2) real engine, constant 64 input -> only DC nonzero
    use_dct = 1'b1;
    for (int r = 0; r < PTS; r++) tbl[r].row = {PTS{16'd64}};
    build_expected();
    send_block(0);
    collect_block(0);
    chk("dc_only_ac_zero", first_col[(PTS-1)*N-1:0], '0);
    chk("dc_nonzero", word_t'(first_col[(PTS-1)*N +: N] != 16'd0), 1);

    // 3) backpressure with 1,0,0 out_ready pattern
    use_dct = 1'b0;
    random_rows();
    build_expected();
    send_block(0);
    collect_block(1);

    // 4) flush after 5 rows (with a simultaneous row offered), new block
    random_rows();
    in_valid = 1'b1;
    for (int r = 0; r < 5; r++) begin
      in_row = tbl[r].row;
      step();
    end
    in_row = tbl[5].row;
    flush  = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    out_ready = 1'b0;
    chk("flush_no_output", seen, 0);
    random_rows();
    build_expected();
    send_block(20);
    collect_block(0);

    // 5) async reset in the middle of COLS
    random_rows();
    build_expected();
    send_block(0);
    out_ready = 1'b1;
    step(); step(); step();
    chk("midcols_out_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_col", out_col, '0);
    #1 reset = 1'b0;
    out_ready = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // 6) randomized blocks through the DCT engine
    use_dct = 1'b1;
    for (int b = 0; b < 6; b++) begin
      random_rows();
      build_expected();
      send_block(30);
      collect_block(2);
    end

`ifdef DCT2D_SEQ_BLKCNT_EN
    // 7) block counter: 3 blocks then flush
    reset = 1'b1;
    #1;
    chk("blkcnt_reset", blk_count, 0);
    step();
    #2 reset = 1'b0;
    step();
    use_dct = 1'b0;
    for (int b = 0; b < 3; b++) begin
      random_rows();
      build_expected();
      send_block(0);
      collect_block(0);
    end
    chk("blkcnt_three", blk_count, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("blkcnt_after_flush", blk_count, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_dct2d_seq
`default_nettype wire
